instr_fetch_queue: RTL and testbench
====================================

# instr_fetch_queue

Parametrised instruction-fetch front end: owns the PC, issues fixed-latency reads to instruction memory, and buffers returned instructions with their PCs in a DEPTH-entry queue feeding decode over a valid/ready handshake. It computes redirect targets for taken branches, JAL and JALR internally, flushes wrong-path state, and halts fetch with a sticky fault on a misaligned target. It replaces the single PC/IR pair in front of the register-file datapath and decouples fetch from decode stalls.

## Interface
- XLEN, 32: PC and operand width; 32 or 64.
- DEPTH, 4: queue entries; power of 2, at least 2.
- RESET_PC, 0: PC loaded on reset.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  read request this cycle.
- imem_addr  out  XLEN  read address, always equal to the PC register.
- imem_rdata  in  32  instruction, valid exactly one cycle after imem_req; memory never stalls.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts head.
- out_instr  out  32  head instruction.
- out_pc  out  XLEN  head PC.
- redir_valid  in  1  redirect this cycle (taken branch, JAL or JALR).
- redir_jalr  in  1  1: target = (redir_rs1 + redir_imm) with bit 0 cleared; 0: target = redir_pc + redir_imm.
- redir_pc  in  XLEN  PC of the redirecting instruction.
- redir_rs1  in  XLEN  register-file operand for JALR.
- redir_imm  in  XLEN  sign-extended immediate.
- fetch_fault  out  1  sticky misaligned-target flag.
- fault_pc  out  XLEN  offending target.

## Operation
- Credit rule: `imem_req = !fetch_fault && !redir_valid && (count + inflight - pop) < DEPTH`.
  - `count` is the queue occupancy.
  - `inflight` is the registered imem_req from the previous cycle, cleared by a redirect.
  - `pop` is out_valid && out_ready.
- Fetch: on each cycle with imem_req = 1, PC <= PC + 4. Arithmetic is modulo 2^XLEN; the PC wraps from all-ones-minus-3 to 0 silently.
- Response: when `inflight` is set, push {imem_rdata, address of that request} at the tail. By the credit rule the queue is never written when full; a push into a full queue is an assertion failure.
- Queue: circular buffer with head/tail pointers of log2(DEPTH) bits plus the count. Push and pop in the same cycle are allowed at any occupancy, including full (count unchanged) and empty-with-push (the head becomes valid next cycle; there is no same-cycle bypass).
- Redirect (redir_valid = 1):
  - The target is computed in XLEN bits.
  - A handshake completing in the same cycle counts as consumed.
  - The queue is emptied, `inflight` is cleared so the response returning next cycle is discarded, and no request is issued.
  - If target[1:0] = 00: PC <= target, and fetch resumes next cycle.
  - Otherwise: fetch_fault <= 1, fault_pc <= target, PC unchanged, and no further requests.
- Fault: fetch_fault clears only on reset or on a later redirect with an aligned target.
- Reset dominates a simultaneous redirect and every other input.

## Timing
- Values during and after reset: PC = RESET_PC, count = 0, inflight = 0, out_valid = 0, fetch_fault = 0, fault_pc = 0.
- imem_req may be 1 in the first cycle after reset is released.
- Fetch latency: request at cycle t, data at t+1, out_valid with out_pc = that address at t+2.
- Redirect penalty: redirect at cycle r, first new request at r+1, out_valid for the target at r+3.
- Steady state: one instruction per cycle with out_ready held high, for any DEPTH ≥ 2.
- out_valid, out_instr and out_pc are registered; imem_req is combinational from out_ready and redir_valid.

## Test plan
- Reset release with RESET_PC = 0x100 and out_ready = 1 -> requests at 0x100, 0x104, 0x108 on consecutive cycles; out_pc = 0x100 two cycles after the first request, then one instruction per cycle in order.
- out_ready = 0 for 10 cycles with DEPTH = 4 -> exactly 4 entries buffered, then imem_req = 0; on release the 4 drain in order and fetch resumes with no PC gap or duplicate.
- Branch redirect with redir_pc = 0x200 and redir_imm = -8 while the queue holds 3 entries and a request is in flight -> queue flushed, in-flight data dropped, next request 0x1F8, and no stale instruction ever reaches decode.
- JALR with rs1 = 0x301 and imm = 0 -> target 0x300, no fault. JALR with rs1 = 0x302 -> fetch_fault = 1, fault_pc = 0x302, imem_req stays 0. A following aligned redirect clears the fault and resumes fetch.
- Redirect and reset asserted in the same cycle -> PC = RESET_PC and queue empty. Reset asserted mid-stream -> all outputs at their reset values the next cycle.
- PC = 0xFFFFFFFC with XLEN = 32 -> the next request is 0x00000000.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues fixed-latency reads to instruction
// memory and buffers {instr, pc} pairs in a DEPTH-entry queue feeding decode.
module instr_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    input  logic            redir_valid,
    input  logic            redir_jalr,
    input  logic [XLEN-1:0] redir_pc,
    input  logic [XLEN-1:0] redir_rs1,
    input  logic [XLEN-1:0] redir_imm,
    output logic            fetch_fault,
    output logic [XLEN-1:0] fault_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [XLEN-1:0] INSN_BYTES = XLEN'(4);
    localparam logic [XLEN-1:0] JALR_MASK  = {{(XLEN-1){1'b1}}, 1'b0};

    typedef logic [PW-1:0] ptr_t;

    logic [31:0]     q_instr [DEPTH];
    logic [XLEN-1:0] q_pc    [DEPTH];
    ptr_t            head;
    ptr_t            tail;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] pc;
    logic            inflight;
    logic [XLEN-1:0] inflight_pc;

    logic            pop;
    logic            push;
    logic [CW:0]     credit_used;
    logic [XLEN-1:0] target;
    logic            target_ok;

    // NOTE: every signal is assigned on every path through this block, so no latch is inferred.
    always_comb begin
        pop         = out_valid && out_ready;
        // A response landing in a redirect cycle belongs to the wrong path and is dropped.
        push        = inflight && !redir_valid;
        credit_used = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
        imem_req    = !fetch_fault && !redir_valid && (credit_used < (CW+1)'(DEPTH));
        target      = redir_jalr ? ((redir_rs1 + redir_imm) & JALR_MASK)
                                 : (redir_pc + redir_imm);
        target_ok   = (target[1:0] == 2'b00);
    end

    assign imem_addr = pc;
    assign out_valid = (count != '0);
    assign out_instr = q_instr[head];
    assign out_pc    = q_pc[head];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            fetch_fault <= 1'b0;
            fault_pc    <= '0;
        end else begin
            inflight    <= imem_req;
            inflight_pc <= pc;
            if (redir_valid) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
                if (target_ok) begin
                    pc          <= target;
                    fetch_fault <= 1'b0;
                end else begin
                    fetch_fault <= 1'b1;
                    fault_pc    <= target;
                end
            end else begin
                if (imem_req) pc   <= pc + INSN_BYTES;
                if (push)     tail <= tail + 1'b1;
                if (pop)      head <= head + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (!push && pop) count <= count - 1'b1;
            end
        end
    end

    // NOTE: queue storage is not reset; count alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            q_instr[tail] <= imem_rdata;
            q_pc[tail]    <= inflight_pc;
        end
    end

    push_into_full: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && count == CW'(DEPTH)));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized scoreboard bench for instr_fetch_queue: the model is the ideal in-order
// instruction stream restarted at each redirect target, checked at every decode handshake.
module tb_instr_fetch_queue;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redir_valid;
    logic        redir_jalr;
    logic [31:0] redir_pc;
    logic [31:0] redir_rs1;
    logic [31:0] redir_imm;
    logic        fetch_fault;
    logic [31:0] fault_pc;

    always #5 clk = ~clk;

    instr_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .redir_valid(redir_valid), .redir_jalr(redir_jalr), .redir_pc(redir_pc),
        .redir_rs1(redir_rs1), .redir_imm(redir_imm),
        .fetch_fault(fetch_fault), .fault_pc(fault_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Instruction memory: one-cycle latency, garbage when no request was made.
    always @(posedge clk) imem_rdata <= imem_req ? mem_word(imem_addr) : $urandom;

    logic [31:0] exp_q [$];
    logic [31:0] gen_pc;
    bit          gen_active;
    bit          m_fault;
    logic [31:0] m_fault_pc;
    bit          mon_en;
    int          n_vec;
    int          n_bad;
    int          n_req;
    int          n_pop;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: samples mid-cycle and consumes the expected stream on each handshake.
    always @(negedge clk) begin
        logic [31:0] e;
        if (mon_en) begin
            if (reset) begin
                n_req = 0;
                n_pop = 0;
            end else begin
                if (imem_req === 1'b1) n_req++;
                if (m_fault) check("no_req_while_fault", imem_req, 1'b0);
            end
            check("fetch_fault", fetch_fault, m_fault);
            check("fault_pc", fault_pc, m_fault_pc);
            if (out_valid === 1'b1 && out_ready) begin
                if (!reset) n_pop++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_pop: got pc %h, expected no instruction", out_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("out_pc", out_pc, e);
                    check("out_instr", out_instr, mem_word(e));
                end
            end
        end
    end

    task automatic drive(input bit rst, input bit rdy, input bit rv, input bit jalr,
                         input logic [31:0] rpc, input logic [31:0] rs1, input logic [31:0] imm);
        reset       = rst;
        out_ready   = rdy;
        redir_valid = rv;
        redir_jalr  = jalr;
        redir_pc    = rpc;
        redir_rs1   = rs1;
        redir_imm   = imm;
    endtask

    // Advance one cycle, then apply the stream model for whatever the edge just saw.
    task automatic tick();
        logic [31:0] t;
        @(posedge clk);
        #1;
        if (reset) begin
            exp_q.delete();
            gen_pc     = RESET_PC;
            gen_active = 1'b1;
            m_fault    = 1'b0;
            m_fault_pc = '0;
            mon_en     = 1'b1;
        end else if (redir_valid) begin
            t = redir_jalr ? ((redir_rs1 + redir_imm) & 32'hFFFF_FFFE) : (redir_pc + redir_imm);
            exp_q.delete();
            if (t[1:0] == 2'b00) begin
                gen_pc     = t;
                gen_active = 1'b1;
                m_fault    = 1'b0;
            end else begin
                gen_active = 1'b0;
                m_fault    = 1'b1;
                m_fault_pc = t;
            end
        end
        while (gen_active && exp_q.size() < 8) begin
            exp_q.push_back(gen_pc);
            gen_pc = gen_pc + 32'd4;
        end
    endtask

    initial begin
        logic [31:0] imm;
        int          r;
        mon_en = 1'b0;
        n_vec  = 0;
        n_bad  = 0;

        // Reset values, then the first three requests and the two-cycle fetch latency.
        drive(1, 1, 0, 0, 0, 0, 0);
        tick();
        tick();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_fault", fetch_fault, 1'b0);
        check("rst_fault_pc", fault_pc, 32'h0);
        drive(0, 1, 0, 0, 0, 0, 0);
        #1;
        check("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, 32'h100);
        tick();
        check("second_addr", imem_addr, 32'h104);
        tick();
        check("third_addr", imem_addr, 32'h108);
        check("first_valid", out_valid, 1'b1);
        check("first_out_pc", out_pc, 32'h100);
        repeat (6) begin
            tick();
            check("throughput_valid", out_valid, 1'b1);
        end

        // Decode stall: queue fills to DEPTH and fetch stops.
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (10) tick();
        check("stall_req", imem_req, 1'b0);
        check("stall_buffered", 32'(n_req - n_pop), 32'(DEPTH));
        drive(0, 1, 0, 0, 0, 0, 0);
        repeat (8) tick();

        // Branch redirect with 3 entries queued and one in flight.
        drive(0, 0, 1, 0, 32'h3F0, 0, 32'h10);
        #1;
        check("redir_blocks_req", imem_req, 1'b0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("jal_addr", imem_addr, 32'h400);
        repeat (4) tick();
        check("three_plus_one_req", imem_req, 1'b0);
        check("three_plus_one_valid", out_valid, 1'b1);
        drive(0, 0, 1, 0, 32'h200, 0, 32'hFFFF_FFF8);
        tick();
        drive(0, 1, 0, 0, 0, 0, 0);
        #1;
        check("branch_addr", imem_addr, 32'h1F8);
        check("branch_req", imem_req, 1'b1);
        check("flushed_valid", out_valid, 1'b0);
        tick();
        tick();
        check("penalty_valid", out_valid, 1'b1);
        check("penalty_pc", out_pc, 32'h1F8);
        repeat (4) tick();

        // JALR aligned, JALR misaligned (fault), then recovery.
        drive(0, 1, 1, 1, 0, 32'h301, 0);
        tick();
        drive(0, 1, 0, 0, 0, 0, 0);
        #1;
        check("jalr_addr", imem_addr, 32'h300);
        check("jalr_no_fault", fetch_fault, 1'b0);
        repeat (5) tick();
        drive(0, 1, 1, 1, 0, 32'h302, 0);
        tick();
        drive(0, 1, 0, 0, 0, 0, 0);
        #1;
        check("mis_fault", fetch_fault, 1'b1);
        check("mis_fault_pc", fault_pc, 32'h302);
        check("mis_req", imem_req, 1'b0);
        repeat (4) tick();
        check("fault_sticky_req", imem_req, 1'b0);
        drive(0, 1, 1, 0, 32'h480, 0, 32'h80);
        tick();
        drive(0, 1, 0, 0, 0, 0, 0);
        #1;
        check("recover_fault", fetch_fault, 1'b0);
        check("recover_req", imem_req, 1'b1);
        check("recover_addr", imem_addr, 32'h500);
        repeat (6) tick();

        // Reset wins over a simultaneous redirect; mid-stream reset clears a fault.
        drive(1, 1, 1, 0, 32'h600, 0, 32'h100);
        tick();
        drive(0, 1, 0, 0, 0, 0, 0);
        #1;
        check("rst_redir_addr", imem_addr, RESET_PC);
        check("rst_redir_valid", out_valid, 1'b0);
        repeat (6) tick();
        drive(0, 1, 1, 1, 0, 32'h303, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        check("midrst_fault", fetch_fault, 1'b0);
        check("midrst_fault_pc", fault_pc, 32'h0);
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_addr", imem_addr, RESET_PC);
        drive(0, 1, 0, 0, 0, 0, 0);
        repeat (4) tick();

        // PC wrap at the top of the address space.
        drive(0, 1, 1, 1, 0, 32'hFFFF_FFF8, 0);
        tick();
        drive(0, 1, 0, 0, 0, 0, 0);
        #1;
        check("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
        tick();
        check("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_addr2", imem_addr, 32'h0000_0000);
        repeat (6) tick();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r   = $urandom_range(0, 999);
            imm = 32'($urandom_range(0, 511)) * 32'd4 - 32'd1024;
            if ($urandom_range(0, 7) == 0) imm = imm + 32'($urandom_range(1, 3));
            drive(r < 3, $urandom_range(0, 9) < 7, (r >= 3) && (r < 63),
                  1'($urandom_range(0, 1)), $urandom & 32'h0000_FFFC,
                  $urandom & 32'h0000_FFFF, imm);
            tick();
        end

        drive(0, 1, 1, 0, 32'h800, 0, 0);
        tick();
        drive(0, 1, 0, 0, 0, 0, 0);
        repeat (10) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
